ctrl_fsm: RTL and testbench
===========================

# ctrl_fsm

Multi-cycle sequencer for the CPU datapath. It produces the 4-bit state code `st` that the control-signal decoder turns into PC_Write, IR_Write, Reg_Write, rs2_imm_s and w_data_s. It steps through fetch, decode, execute and writeback based on the opcode held in the instruction register. It also keeps retire and cycle counters and flags illegal opcodes.

## Interface
- `CNT_W`, default 32: width of the instruction and cycle counters.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `run`, in, 1: level. High lets the sequencer start or continue fetching.
- `opcode`, in, 7: IR[6:0]. Valid from state 2 onward, since IR is written at the end of state 1.
- `st`, out, 4: current state code for the control decoder.
- `busy`, out, 1: high whenever `st != 0`.
- `retire`, out, 1: one-cycle pulse in the last cycle of each instruction (state 4 or 6).
- `illegal`, out, 1: sticky error flag.
- `instr_cnt`, out, CNT_W: count of retired instructions.
- `cyc_cnt`, out, CNT_W: count of cycles spent with `busy` high.

## Operation
- State codes, fixed:
  - 0 IDLE
  - 1 FETCH
  - 2 DECODE
  - 3 EXEC_R
  - 4 WB_ALU
  - 5 EXEC_I
  - 6 WB_LUI
  - 7–15 unused.
- Transitions, evaluated each rising edge:
  - IDLE → FETCH if `run && !illegal`, else stay in IDLE.
  - FETCH → DECODE, unconditionally.
  - DECODE, by `opcode`:
    - 7'b0110011 (R-type) → EXEC_R.
    - 7'b0010011 (I-type ALU) → EXEC_I.
    - 7'b0110111 (LUI) → WB_LUI.
    - Any other value → IDLE, and `illegal` is set.
  - EXEC_R → WB_ALU; EXEC_I → WB_ALU.
  - WB_ALU / WB_LUI → FETCH if `run`, else IDLE.
  - Unused codes 7–15 → IDLE on the next edge, with no flag and no count.
- `run` is sampled only in IDLE, WB_ALU and WB_LUI. Dropping `run` mid-instruction lets that instruction complete; it never aborts.
- `illegal` stays set until `rst`. While it is set, IDLE is held regardless of `run`.
- `retire` = (st == 4) || (st == 6), combinational from the state register.
- `instr_cnt` increments on each edge where `retire` is high. `cyc_cnt` increments on each edge where `busy` is high.
- Both counters wrap modulo 2^CNT_W with no saturation and no flag.

## Timing
- Reset values: `st` = 0, `busy` = 0, `retire` = 0, `illegal` = 0, `instr_cnt` = 0, `cyc_cnt` = 0.
- `rst` wins over every other input, including mid-instruction. State returns to IDLE on that edge and the in-flight instruction is neither counted nor flagged.
- Latency from `run` asserting in IDLE: FETCH on the next edge.
- Cycles per instruction, counted from FETCH:
  - R-type: 4 (1, 2, 3, 4).
  - I-type: 4 (1, 2, 5, 4).
  - LUI: 3 (1, 2, 6).
  - Illegal: 2 (1, 2), then IDLE.
- Back-to-back with `run` held high: FETCH immediately follows the writeback state, with no IDLE bubble.
- `opcode` is sampled only in DECODE. Changes in any other state are ignored.
- All outputs are registered, or are pure decodes of the state register. There is no combinational path from any input to any output.
- Simultaneous events at the wrap boundary: retire and cycle increments land on the same edge and both wrap independently.

## Structure
- Shared package `cpu_pkg` holds:
  - the state constants `ST_IDLE`..`ST_WB_LUI` (4-bit), shared with the control decoder;
  - the opcode constants `OP_R`, `OP_I`, `OP_LUI`.
- One sub-module, `op_class`: combinational classification of `opcode` into {R, I, LUI, ILLEGAL}. It is instantiated once and used only in DECODE.
- The counters live inline in `ctrl_fsm`.

## Test plan
- **Reset, then R-type.** Reset, `run`=1, `opcode`=7'h33. Required:
  - `st` sequence 0, 1, 2, 3, 4, 1;
  - `retire` high only in the state-4 cycle;
  - `instr_cnt`=1 and `cyc_cnt`=4 after the first WB.
- **Mixed stream.** `run`=1, opcodes I-type (7'h13), then LUI (7'h37), then R-type. Required:
  - states 1, 2, 5, 4, 1, 2, 6, 1, 2, 3, 4;
  - `instr_cnt`=3 and `cyc_cnt`=11.
- **Illegal opcode.** `opcode`=7'h7F in DECODE. Required:
  - next `st`=0 and `illegal`=1;
  - `instr_cnt` unchanged;
  - state stays 0 for 10 cycles with `run`=1;
  - `rst` clears `illegal`.
- **Run drop.** `run` falls during EXEC_R. Required: the instruction completes through 4 and `instr_cnt` increments. Then `st`=0, `busy`=0, and `cyc_cnt` freezes.
- **Mid-op reset.** Assert `rst` during EXEC_I for one cycle. Required: `st`=0 and all counters 0 on the next edge, with no `retire` pulse.
- **Counter wrap.** With `CNT_W`=4, run 16 R-type instructions. Required: `instr_cnt` wraps to 0, and `cyc_cnt` = 64 mod 16 = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state codes, opcode constants and the
// opcode classes used by the decode step.
package cpu_pkg;

  // State codes are fixed; the control-signal decoder keys off these values.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC_R = 4'd3,
    ST_WB_ALU = 4'd4,
    ST_EXEC_I = 4'd5,
    ST_WB_LUI = 4'd6
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [1:0] {
    OPC_R,
    OPC_I,
    OPC_LUI,
    OPC_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/op_class.sv
// Combinational opcode classifier; the sequencer only consults it in DECODE.
module op_class
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  cls
);

  always_comb begin
    cls = OPC_ILLEGAL;
    case (opcode)
      OP_R:    cls = OPC_R;
      OP_I:    cls = OPC_I;
      OP_LUI:  cls = OPC_LUI;
      default: cls = OPC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with retire and busy
// cycle counters and a sticky illegal-opcode flag.
module ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  output logic [3:0]       st,
  output logic             busy,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cyc_cnt
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  op_class_e        op_cls;

  op_class u_op_class (
    .opcode (opcode),
    .cls    (op_cls)
  );

  // run is only looked at in IDLE and the writeback states, so an instruction
  // already fetched always runs to completion.
  always_comb begin
    state_d   = ST_IDLE;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:   state_d = (run && !illegal_q) ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (op_cls)
          OPC_R:   state_d = ST_EXEC_R;
          OPC_I:   state_d = ST_EXEC_I;
          OPC_LUI: state_d = ST_WB_LUI;
          default: begin
            state_d   = ST_IDLE;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_EXEC_R: state_d = ST_WB_ALU;
      ST_EXEC_I: state_d = ST_WB_ALU;
      ST_WB_ALU: state_d = run ? ST_FETCH : ST_IDLE;
      ST_WB_LUI: state_d = run ? ST_FETCH : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign retire = (state_q == ST_WB_ALU) || (state_q == ST_WB_LUI);

  always_comb begin
    instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, retire};
    cyc_cnt_d   = cyc_cnt_q + {{(CNT_W-1){1'b0}}, busy};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      illegal_q   <= 1'b0;
      instr_cnt_q <= '0;
      cyc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      instr_cnt_q <= instr_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
    end
  end

  assign st        = state_q;
  assign illegal   = illegal_q;
  assign instr_cnt = instr_cnt_q;
  assign cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: directed scenarios with literal checks, plus a per-cycle
// comparison against an instruction-level model (32-bit and 4-bit counters).
module tb_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        run;
  logic [6:0]  opcode;

  logic [3:0]  st, st4;
  logic        busy, busy4, retire, retire4, illegal, illegal4;
  logic [31:0] instr_cnt, cyc_cnt;
  logic [3:0]  instr_cnt4, cyc_cnt4;

  int total = 0;
  int bad   = 0;

  ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .st(st), .busy(busy), .retire(retire), .illegal(illegal),
    .instr_cnt(instr_cnt), .cyc_cnt(cyc_cnt)
  );

  ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .st(st4), .busy(busy4), .retire(retire4), .illegal(illegal4),
    .instr_cnt(instr_cnt4), .cyc_cnt(cyc_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [6:0] op, input logic rs);
    run    = r;
    opcode = op;
    rst    = rs;
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: each instruction is a list of state codes taken
  // from its cycles-per-instruction table; the tail is chosen in DECODE.
  int               m_st;
  int               m_pend[$];
  bit               m_ill;
  longint unsigned  m_instr, m_cyc;
  bit               model_valid = 1'b0;

  always @(posedge clk) begin : model_blk
    int nxt;
    if (rst) begin
      m_st = 0;
      m_pend.delete();
      m_ill = 1'b0;
      m_instr = 0;
      m_cyc = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (m_st == 4 || m_st == 6) m_instr++;
      if (m_st != 0) m_cyc++;
      if (m_st == 2) begin
        case (opcode)
          7'h33:   m_pend = '{3, 4};
          7'h13:   m_pend = '{5, 4};
          7'h37:   m_pend = '{6};
          default: begin
            m_pend.delete();
            m_ill = 1'b1;
          end
        endcase
      end
      if (m_pend.size() > 0) begin
        nxt = m_pend.pop_front();
      end else if (run && !m_ill) begin
        nxt = 1;
        m_pend = '{2};
      end else begin
        nxt = 0;
      end
      m_st = nxt;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("cyc_st", st, m_st);
      checkOutput("cyc_busy", busy, m_st != 0);
      checkOutput("cyc_retire", retire, (m_st == 4) || (m_st == 6));
      checkOutput("cyc_illegal", illegal, m_ill);
      checkOutput("cyc_instr", instr_cnt, m_instr & 64'hFFFF_FFFF);
      checkOutput("cyc_cyc", cyc_cnt, m_cyc & 64'hFFFF_FFFF);
      checkOutput("cyc_st4", st4, m_st);
      checkOutput("cyc_instr4", instr_cnt4, m_instr & 64'hF);
      checkOutput("cyc_cyc4", cyc_cnt4, m_cyc & 64'hF);
    end
  end

  int exp_r[5]      = '{1, 2, 3, 4, 1};
  int exp_r_ret[5]  = '{0, 0, 0, 1, 0};
  int exp_mix[11]   = '{1, 2, 5, 4, 1, 2, 6, 1, 2, 3, 4};
  logic [6:0] op_mix[11] = '{7'h13, 7'h13, 7'h13, 7'h13, 7'h13, 7'h13,
                             7'h37, 7'h37, 7'h37, 7'h33, 7'h33};

  initial begin
    run = 1'b0; opcode = 7'h00; rst = 1'b1;

    // Reset, then a single R-type.
    applyStimulus(1'b0, 7'h00, 1'b1);
    checkOutput("reset_st", st, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_retire", retire, 0);
    checkOutput("reset_illegal", illegal, 0);
    checkOutput("reset_instr", instr_cnt, 0);
    checkOutput("reset_cyc", cyc_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 7'h33, 1'b0);
      checkOutput($sformatf("r_st%0d", i), st, exp_r[i]);
      checkOutput($sformatf("r_retire%0d", i), retire, exp_r_ret[i]);
    end
    checkOutput("r_instr", instr_cnt, 1);
    checkOutput("r_cyc", cyc_cnt, 4);
    checkOutput("model_r_cyc", m_cyc, 4);

    // Mixed I / LUI / R stream.
    applyStimulus(1'b0, 7'h00, 1'b1);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, op_mix[i], 1'b0);
      checkOutput($sformatf("mix_st%0d", i), st, exp_mix[i]);
    end
    applyStimulus(1'b1, 7'h33, 1'b0);
    checkOutput("mix_instr", instr_cnt, 3);
    checkOutput("mix_cyc", cyc_cnt, 11);
    checkOutput("model_mix_instr", m_instr, 3);

    // Illegal opcode locks the sequencer in IDLE until reset.
    applyStimulus(1'b0, 7'h00, 1'b1);
    applyStimulus(1'b1, 7'h7F, 1'b0);
    applyStimulus(1'b1, 7'h7F, 1'b0);
    checkOutput("ill_decode", st, 2);
    applyStimulus(1'b1, 7'h7F, 1'b0);
    checkOutput("ill_st", st, 0);
    checkOutput("ill_flag", illegal, 1);
    checkOutput("ill_instr", instr_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 7'h33, 1'b0);
      checkOutput($sformatf("ill_hold%0d", i), st, 0);
    end
    checkOutput("model_ill", m_ill, 1);
    applyStimulus(1'b1, 7'h33, 1'b1);
    checkOutput("ill_cleared", illegal, 0);

    // Run drops during EXEC_R: the instruction still completes.
    applyStimulus(1'b0, 7'h00, 1'b1);
    applyStimulus(1'b1, 7'h33, 1'b0);
    applyStimulus(1'b1, 7'h33, 1'b0);
    applyStimulus(1'b1, 7'h33, 1'b0);
    checkOutput("drop_exec", st, 3);
    applyStimulus(1'b0, 7'h33, 1'b0);
    checkOutput("drop_wb", st, 4);
    applyStimulus(1'b0, 7'h33, 1'b0);
    checkOutput("drop_st", st, 0);
    checkOutput("drop_busy", busy, 0);
    checkOutput("drop_instr", instr_cnt, 1);
    checkOutput("drop_cyc", cyc_cnt, 4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 7'h33, 1'b0);
    checkOutput("drop_cyc_frozen", cyc_cnt, 4);

    // Reset in the middle of an I-type.
    applyStimulus(1'b0, 7'h00, 1'b1);
    applyStimulus(1'b1, 7'h13, 1'b0);
    applyStimulus(1'b1, 7'h13, 1'b0);
    applyStimulus(1'b1, 7'h13, 1'b0);
    checkOutput("midrst_exec", st, 5);
    applyStimulus(1'b1, 7'h13, 1'b1);
    checkOutput("midrst_st", st, 0);
    checkOutput("midrst_retire", retire, 0);
    checkOutput("midrst_instr", instr_cnt, 0);
    checkOutput("midrst_cyc", cyc_cnt, 0);
    applyStimulus(1'b0, 7'h13, 1'b0);
    checkOutput("midrst_idle", st, 0);
    checkOutput("midrst_noretire", instr_cnt, 0);

    // 16 back-to-back R-types: 4-bit counters wrap together on the 65th edge.
    applyStimulus(1'b0, 7'h00, 1'b1);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 7'h33, 1'b0);
    checkOutput("wrap_pre_instr4", instr_cnt4, 15);
    checkOutput("wrap_pre_cyc4", cyc_cnt4, 15);
    applyStimulus(1'b1, 7'h33, 1'b0);
    checkOutput("wrap_instr4", instr_cnt4, 0);
    checkOutput("wrap_cyc4", cyc_cnt4, 0);
    checkOutput("wrap_instr32", instr_cnt, 16);
    checkOutput("wrap_cyc32", cyc_cnt, 64);
    checkOutput("wrap_st", st, 1);

    applyStimulus(1'b0, 7'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
